// File: rtl/uart_program_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and constants for the UART program loader.
//                Holds the loader and receiver state encodings, the frame
//                sync byte and the frame field order.
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Frame field order: SYNC, LEN_LO, LEN_HI, 4*N data bytes, CHK.
    localparam int FIELD_SYNC     = 0;
    localparam int FIELD_LEN_LO   = 1;
    localparam int FIELD_LEN_HI   = 2;
    localparam int FIELD_DATA     = 3;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // True while a frame is being received; these states are subject to
    // frame-error and inter-byte timeout aborts.
    function automatic logic is_loading(input loader_state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) ||
               (s == ST_DATA)   || (s == ST_CHECK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_program_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_program_loader_if
//  Description : Instruction-memory write port and core-control signals of
//                the program loader.
//                imem_we/imem_addr/imem_wdata : one-cycle imem write
//                core_hold                    : holds the core in reset
//                busy/done/error              : load status
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_program_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  core_hold;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output imem_we, imem_addr, imem_wdata, core_hold, busy, done, error
    );

    modport slave (
        input imem_we, imem_addr, imem_wdata, core_hold, busy, done, error
    );
endinterface
`default_nettype wire

// File: rtl/uart_program_loader_byte_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_rx
//  Description : 8N1 UART byte receiver. 2-FF synchronizer, falling-edge
//                start detect with half-bit re-check, mid-bit sampling.
//                clk, reset_n   : clock, synchronous active-low reset
//                rx_i           : asynchronous serial input (idles high)
//                byte_valid_o   : 1-cycle pulse, byte_data_o is valid
//                byte_data_o    : received byte
//                frame_err_o    : 1-cycle pulse, stop bit was 0 (byte dropped)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic       rx_i,
    output logic            byte_valid_o,
    output logic [7:0]      byte_data_o,
    output logic            frame_err_o
);
    localparam int            CW       = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    logic rx_w;
    logic fall_w;

    assign rx_w   = sync_q[1];
    assign fall_w = prev_q & ~rx_w;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= rx_w;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (fall_w) state_d = RX_START;
            end
            RX_START: begin
                // A glitch that is high again at half-bit is not a start bit.
                if (cnt_q == HALF_BIT) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_w ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d   = '0;
                    shift_d = {rx_w, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_w) valid_d = 1'b1;
                    else      ferr_d  = 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid_o = valid_q;
    assign byte_data_o  = shift_q;
    assign frame_err_o  = ferr_q;

endmodule
`default_nettype wire

// File: rtl/uart_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_program_loader
//  Description : Serial boot loader. Receives SYNC/LEN/DATA/CHK frames over
//                UART and writes little-endian 32-bit words to imem, holding
//                the core in reset while loading.
//                clk, reset_n : clock, synchronous active-low reset
//                uart_rx      : serial input, 8N1, LSB first
//                bus          : imem write port and core_hold/busy/done/error
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int CLK_FREQ       = 100000000,
    parameter int BAUD           = 115200,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              uart_rx,
    uart_program_loader_if.master  bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int MAX_WORDS    = 2 ** ADDR_WIDTH;
    localparam int GW           = $clog2(TIMEOUT_CYCLES + 1);

    logic       byte_valid_w;
    logic [7:0] byte_data_w;
    logic       frame_err_w;

    uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_i         (uart_rx),
        .byte_valid_o (byte_valid_w),
        .byte_data_o  (byte_data_w),
        .frame_err_o  (frame_err_w)
    );

    loader_state_t         state_q, state_d;
    logic [15:0]           len_q, len_d;
    // One extra bit so the index can reach MAX_WORDS without wrapping.
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [31:0]           word_q, word_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [7:0]            chk_q, chk_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  hold_q, hold_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  fail_w;
    logic [15:0]           nwords_w;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            bcnt_q  <= '0;
            chk_q   <= '0;
            gap_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            bcnt_q  <= bcnt_d;
            chk_q   <= chk_d;
            gap_q   <= gap_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign nwords_w = {byte_data_w, len_q[7:0]};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        word_d  = word_q;
        bcnt_d  = bcnt_q;
        chk_d   = chk_q;
        gap_d   = gap_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
        fail_w  = 1'b0;

        if (is_loading(state_q)) begin
            gap_d = byte_valid_w ? '0 : gap_q + GW'(1);
            if (frame_err_w ||
                (!byte_valid_w && gap_q == GW'(TIMEOUT_CYCLES - 1)))
                fail_w = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (byte_valid_w && byte_data_w == SYNC_BYTE) begin
                    state_d = ST_LEN_LO;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    hold_d  = 1'b1;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    chk_d   = '0;
                    bcnt_d  = '0;
                    gap_d   = '0;
                end
            end
            ST_LEN_LO: begin
                if (byte_valid_w) begin
                    len_d[7:0] = byte_data_w;
                    state_d    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (byte_valid_w) begin
                    len_d = nwords_w;
                    if (32'(nwords_w) > 32'(MAX_WORDS)) fail_w  = 1'b1;
                    else if (nwords_w == 16'd0)         state_d = ST_CHECK;
                    else                                state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (byte_valid_w) begin
                    // Little-endian: earlier bytes end up in the low lanes.
                    word_d = {byte_data_w, word_q[31:8]};
                    chk_d  = chk_q ^ byte_data_w;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = idx_q[ADDR_WIDTH-1:0];
                        wdata_d = {byte_data_w, word_q[31:8]};
                        idx_d   = idx_q + 1'b1;
                        if (32'(idx_q) + 32'd1 == 32'(len_q)) state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (byte_valid_w) begin
                    if (byte_data_w == chk_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        hold_d  = 1'b0;
                    end else begin
                        fail_w = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // core_hold is deliberately left high: a failed image must not run.
        if (fail_w) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
            done_d  = 1'b0;
            busy_d  = 1'b0;
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.core_hold  = hold_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

endmodule
`default_nettype wire
